// File: rtl/ysyx_24080014_pc_pkg.sv
// Shared types and helpers for the IFU PC generator.
package ysyx_24080014_pc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of the outstanding-fetch counter (covers MAX_INFLIGHT up to 7).
  localparam int INFL_W = 3;

  // Mask that clears the sub-instruction offset bits of an address.
  function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
    return ~(64'(inst_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/ysyx_24080014_pc_hist.sv
// Commit-PC history ring buffer. Index 0 reads the newest entry; the read
// port is registered, so data follows hist_idx by one cycle.
module ysyx_24080014_pc_hist #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic [IW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [IW-1:0]   wptr;

  // Write at wptr (wraps naturally), read relative to the newest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + IW'(1);
      end
      rd_data <= mem[wptr - IW'(1) - rd_idx];
    end
  end

endmodule

// File: rtl/ysyx_24080014_pc_gen.sv
// IFU front-end PC generator: sequential fetch with bounded in-flight count,
// epoch-tagged redirects (trap > taken commit > sequential), commit pulse.
// Optional commit history buffer is built when YSYX_PC_HIST_EN is defined.
module ysyx_24080014_pc_gen
  import ysyx_24080014_pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = 32'h8000_0000,
  parameter int              INST_BYTES   = 4,
  parameter int              MAX_INFLIGHT = 2,
  parameter int              HIST_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          boot_en,
  output logic                          pc_valid,
  input  logic                          pc_ready,
  output logic [XLEN-1:0]               pc,
  output logic                          pc_epoch,
  input  logic                          cmt_valid,
  input  logic                          cmt_epoch,
  input  logic [XLEN-1:0]               cmt_pc,
  input  logic                          cmt_taken,
  input  logic [XLEN-1:0]               cmt_next_pc,
  input  logic                          trap_valid,
  input  logic [XLEN-1:0]               trap_pc,
  output logic                          flush,
  output logic [INFL_W-1:0]             inflight,
  output logic                          cmt_pulse,
  output logic                          err,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc
);

  localparam logic [XLEN-1:0]   MASK = XLEN'(align_mask(INST_BYTES));
  localparam logic [XLEN-1:0]   INC  = XLEN'(INST_BYTES);
  localparam logic [INFL_W-1:0] MAXI = INFL_W'(MAX_INFLIGHT);

  state_t            state;
  logic [XLEN-1:0]   pc_r;
  logic              epoch_r;
  logic [INFL_W-1:0] infl_r, infl_nxt;
  logic              flush_r, pulse_r, err_r;

  logic            fire, cmt_acc, cmt_ok, cmt_bad, redirect, misalign;
  logic [XLEN-1:0] target;

  // pc_valid depends on registers only; the flush cycle is a bubble.
  assign pc_valid = (state == RUN) && (infl_r < MAXI) && !flush_r;
  assign fire     = pc_valid && pc_ready;

  // A commit counts only in the current epoch; with nothing outstanding it
  // is a protocol error and has no other effect.
  assign cmt_acc  = cmt_valid && (cmt_epoch == epoch_r);
  assign cmt_ok   = cmt_acc && (infl_r != '0);
  assign cmt_bad  = cmt_acc && (infl_r == '0);
  assign redirect = trap_valid || (cmt_ok && cmt_taken);
  assign target   = trap_valid ? trap_pc : cmt_next_pc;
  assign misalign = |(target & ~MASK);

  // Outstanding-count update; a redirect discards everything in flight.
  always_comb begin
    infl_nxt = infl_r;
    if (redirect)              infl_nxt = '0;
    else if (fire && !cmt_ok)  infl_nxt = infl_r + INFL_W'(1);
    else if (!fire && cmt_ok)  infl_nxt = infl_r - INFL_W'(1);
  end

  // Boot FSM: IDLE until boot_en, then RUN until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               state <= IDLE;
    else if (state == IDLE && boot_en)     state <= RUN;
  end

  // PC, epoch and flush/pulse/error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= RESET_VEC;
      epoch_r <= 1'b0;
      infl_r  <= '0;
      flush_r <= 1'b0;
      pulse_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (redirect) begin
        pc_r    <= target & MASK;
        epoch_r <= ~epoch_r;
      end else if (fire) begin
        pc_r    <= pc_r + INC;
      end
      infl_r  <= infl_nxt;
      flush_r <= redirect;
      pulse_r <= cmt_ok;
      err_r   <= err_r | cmt_bad | (redirect && misalign);
    end
  end

  assign pc        = pc_r;
  assign pc_epoch  = epoch_r;
  assign inflight  = infl_r;
  assign flush     = flush_r;
  assign cmt_pulse = pulse_r;
  assign err       = err_r;

`ifdef YSYX_PC_HIST_EN
  ysyx_24080014_pc_hist #(
    .XLEN  (XLEN),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmt_ok),
    .wr_data (cmt_pc),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );
`else
  logic unused_hist;
  assign unused_hist = ^{hist_idx, cmt_pc};
  assign hist_pc     = '0;
`endif

endmodule

// File: tb/tb_ysyx_24080014_pc_gen.sv
// Scoreboard bench for ysyx_24080014_pc_gen: expected fetches and commit
// pulses are queued as stimulus is driven and checked by a negedge monitor.
module tb_ysyx_24080014_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_en = 1'b0;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic [31:0] pc;
  logic        pc_epoch;
  logic        cmt_valid = 1'b0;
  logic        cmt_epoch = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        cmt_taken = 1'b0;
  logic [31:0] cmt_next_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        flush;
  logic [2:0]  inflight;
  logic        cmt_pulse;
  logic        err;
  logic [2:0]  hist_idx = '0;
  logic [31:0] hist_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] fetch_q [$];   // {epoch, pc}
  int          pulse_q [$];
  logic        m_epoch = 1'b0;

  ysyx_24080014_pc_gen dut (
    .clk(clk), .rst(rst), .boot_en(boot_en),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc), .pc_epoch(pc_epoch),
    .cmt_valid(cmt_valid), .cmt_epoch(cmt_epoch), .cmt_pc(cmt_pc),
    .cmt_taken(cmt_taken), .cmt_next_pc(cmt_next_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .flush(flush), .inflight(inflight), .cmt_pulse(cmt_pulse), .err(err),
    .hist_idx(hist_idx), .hist_pc(hist_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every fire and every cmt_pulse must match the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_valid && pc_ready) begin
        n_checks++;
        if (fetch_q.size() == 0) begin
          n_fail++;
          $display("FAIL fetch_unexpected got pc=%h epoch=%0d", pc, pc_epoch);
        end else begin
          logic [32:0] e;
          e = fetch_q.pop_front();
          if ({pc_epoch, pc} !== e) begin
            n_fail++;
            $display("FAIL fetch got %h/%0d want %h/%0d", pc, pc_epoch, e[31:0], e[32]);
          end
        end
      end
      if (cmt_pulse) begin
        n_checks++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL cmt_pulse_unexpected got 1 want 0");
        end else begin
          void'(pulse_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    // plain comparison recorder used by the scenario tasks below is avoided;
    // each scenario does its own compares
  endtask

  task automatic clr_cmt();
    cmt_valid = 1'b0; cmt_taken = 1'b0; trap_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({pc_valid, pc_epoch, inflight, flush, cmt_pulse, err} !== 8'b0 ||
        pc !== 32'h8000_0000 || hist_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got pc=%h v=%0d e=%0d infl=%0d fl=%0d p=%0d err=%0d h=%h want pc=80000000 rest 0",
               pc, pc_valid, pc_epoch, inflight, flush, cmt_pulse, err, hist_pc);
    end
  endtask

  task automatic test_boot();
    rst = 1'b0; boot_en = 1'b1; m_epoch = 1'b0;
    tick();                                  // IDLE -> RUN
    fetch_q.push_back({1'b0, 32'h8000_0000});
    fetch_q.push_back({1'b0, 32'h8000_0004});
    pc_ready = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (pc_valid !== 1'b0 || inflight !== 3'd2 || pc !== 32'h8000_0008 || fetch_q.size() != 0) begin
      n_fail++;
      $display("FAIL boot_stall got v=%0d infl=%0d pc=%h pend=%0d want v=0 infl=2 pc=80000008 pend=0",
               pc_valid, inflight, pc, fetch_q.size());
    end
  endtask

  task automatic test_commit();
    pc_ready = 1'b0;
    cmt_valid = 1'b1; cmt_epoch = 1'b0; cmt_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmt_pc = 32'h8000_0000 + 32'(i * 4);
      pulse_q.push_back(i);
      tick();
      n_checks++;
      if (inflight !== 3'(1 - i)) begin
        n_fail++;
        $display("FAIL commit_infl got %0d want %0d", inflight, 1 - i);
      end
    end
    clr_cmt();
    fetch_q.push_back({1'b0, 32'h8000_0008});
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    n_checks++;
    if (pc !== 32'h8000_000C || inflight !== 3'd1) begin
      n_fail++;
      $display("FAIL commit_resume got pc=%h infl=%0d want 8000000c 1", pc, inflight);
    end
  endtask

  task automatic test_redirect();
    // taken commit in the same cycle as a fire: fired PC leaves in old epoch
    fetch_q.push_back({1'b0, 32'h8000_000C});
    pc_ready = 1'b1;
    cmt_valid = 1'b1; cmt_epoch = 1'b0; cmt_pc = 32'h8000_0008;
    cmt_taken = 1'b1; cmt_next_pc = 32'h8000_1000;
    pulse_q.push_back(2);
    m_epoch = ~m_epoch;
    tick();
    clr_cmt();
    pc_ready = 1'b0;
    n_checks++;
    if (flush !== 1'b1 || pc_valid !== 1'b0 || pc_epoch !== m_epoch || inflight !== 3'd0) begin
      n_fail++;
      $display("FAIL redirect_flush got fl=%0d v=%0d e=%0d infl=%0d want 1 0 %0d 0",
               flush, pc_valid, pc_epoch, inflight, m_epoch);
    end
    tick();
    n_checks++;
    if (flush !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h8000_1000) begin
      n_fail++;
      $display("FAIL redirect_target got fl=%0d v=%0d pc=%h want 0 1 80001000", flush, pc_valid, pc);
    end
    fetch_q.push_back({m_epoch, 32'h8000_1000});
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    // stale-epoch commit is silently dropped
    cmt_valid = 1'b1; cmt_epoch = ~m_epoch; cmt_pc = 32'h8000_000C;
    tick();
    clr_cmt();
    tick();
    n_checks++;
    if (inflight !== 3'd1 || err !== 1'b0 || pc !== 32'h8000_1004) begin
      n_fail++;
      $display("FAIL stale_drop got infl=%0d err=%0d pc=%h want 1 0 80001004", inflight, err, pc);
    end
  endtask

  task automatic test_trap();
    trap_valid = 1'b1; trap_pc = 32'h8000_0100;
    cmt_valid = 1'b1; cmt_epoch = m_epoch; cmt_pc = 32'h8000_1000;
    cmt_taken = 1'b1; cmt_next_pc = 32'h8000_2000;
    pulse_q.push_back(3);
    m_epoch = ~m_epoch;
    tick();
    clr_cmt();
    n_checks++;
    if (flush !== 1'b1 || pc_epoch !== m_epoch) begin
      n_fail++;
      $display("FAIL trap_flush got fl=%0d e=%0d want 1 %0d", flush, pc_epoch, m_epoch);
    end
    tick();
    n_checks++;
    if (pc !== 32'h8000_0100 || pc_valid !== 1'b1 || inflight !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_priority got pc=%h v=%0d infl=%0d err=%0d want 80000100 1 0 0",
               pc, pc_valid, inflight, err);
    end
  endtask

  task automatic test_misalign();
    fetch_q.push_back({m_epoch, 32'h8000_0100});
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    cmt_valid = 1'b1; cmt_epoch = m_epoch; cmt_pc = 32'h8000_0100;
    cmt_taken = 1'b1; cmt_next_pc = 32'h8000_0102;
    pulse_q.push_back(4);
    m_epoch = ~m_epoch;
    tick();
    clr_cmt();
    tick();
    n_checks++;
    if (pc !== 32'h8000_0100 || err !== 1'b1 || pc_epoch !== m_epoch) begin
      n_fail++;
      $display("FAIL misalign got pc=%h err=%0d e=%0d want 80000100 1 %0d", pc, err, pc_epoch, m_epoch);
    end
    repeat (3) tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %0d want 1", err);
    end
  endtask

  task automatic test_wrap();
    trap_valid = 1'b1; trap_pc = 32'hFFFF_FFFC;
    m_epoch = ~m_epoch;
    tick();
    clr_cmt();
    tick();
    fetch_q.push_back({m_epoch, 32'hFFFF_FFFC});
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    n_checks++;
    if (pc !== 32'h0000_0000 || inflight !== 3'd1) begin
      n_fail++;
      $display("FAIL pc_wrap got pc=%h infl=%0d want 00000000 1", pc, inflight);
    end
  endtask

  task automatic test_async_reset();
    tick();
    n_checks++;
    if (fetch_q.size() != 0 || pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_before_reset got fetch=%0d pulse=%0d want 0 0", fetch_q.size(), pulse_q.size());
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pc_valid, pc_epoch, inflight, flush, cmt_pulse, err} !== 8'b0 || pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL async_reset got pc=%h v=%0d e=%0d infl=%0d fl=%0d p=%0d err=%0d want 80000000 rest 0",
               pc, pc_valid, pc_epoch, inflight, flush, cmt_pulse, err);
    end
    m_epoch = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    tick();
    rst = 1'b0; boot_en = 1'b1;
    tick();
    exp_pc = 32'h8000_0000;
    fetch_q.push_back({1'b0, exp_pc});
    exp_pc += 32'd4;
    pc_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      cmt_valid = 1'b1; cmt_epoch = 1'b0; cmt_taken = 1'b0;
      cmt_pc = 32'h0000_1000 + 32'(i * 4);
      pulse_q.push_back(10 + i);
      fetch_q.push_back({1'b0, exp_pc});
      exp_pc += 32'd4;
      tick();
    end
    clr_cmt();
    pc_ready = 1'b0;
    tick();
    n_checks++;
    if (inflight !== 3'd1 || pc !== exp_pc || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b got infl=%0d pc=%h err=%0d want 1 %h 0", inflight, pc, err, exp_pc);
    end
    hist_idx = 3'd0;
    tick();
`ifdef YSYX_PC_HIST_EN
    n_checks++;
    if (hist_pc !== 32'h0000_1020) begin
      n_fail++;
      $display("FAIL hist_newest got %h want 00001020", hist_pc);
    end
    hist_idx = 3'd7;
    tick();
    n_checks++;
    if (hist_pc !== 32'h0000_1004) begin
      n_fail++;
      $display("FAIL hist_oldest got %h want 00001004", hist_pc);
    end
`else
    n_checks++;
    if (hist_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL hist_tied got %h want 00000000", hist_pc);
    end
`endif
    tick();
    n_checks++;
    if (fetch_q.size() != 0 || pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got fetch=%0d pulse=%0d want 0 0", fetch_q.size(), pulse_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_commit();
    test_redirect();
    test_trap();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_pc_gen.md
Name: ysyx_24080014_pc_gen

Overview:
Parametrised PC generator for the IFU front end. It issues sequential fetch PCs over a valid/ready handshake and allows up to MAX_INFLIGHT un-committed fetches. Redirects on taken-branch commits or traps are epoch-tagged, so stale in-flight fetches are discarded. It emits a per-commit pulse for the difftest/trace layer.

Parameters:
XLEN, 32, PC and target width
RESET_VEC, 32'h8000_0000, first PC after reset
INST_BYTES, 4, sequential increment; power of two
MAX_INFLIGHT, 2, max issued-but-uncommitted fetches, 1..7
HIST_DEPTH, 8, commit-history entries (only with PC_HIST_EN); power of two

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
boot_en  in  1  leave IDLE and start fetching
pc_valid  out  1  fetch PC valid
pc_ready  in  1  IFU accepts PC
pc  out  XLEN  fetch PC
pc_epoch  out  1  epoch tag of pc
cmt_valid  in  1  instruction commit
cmt_epoch  in  1  epoch tag of committing instruction
cmt_pc  in  XLEN  PC of committing instruction
cmt_taken  in  1  commit redirects flow
cmt_next_pc  in  XLEN  redirect target when cmt_taken
trap_valid  in  1  trap/exception redirect
trap_pc  in  XLEN  trap vector
flush  out  1  one-cycle pulse on any redirect
inflight  out  3  outstanding fetch count
cmt_pulse  out  1  accepted (current-epoch) commit, one cycle
err  out  1  sticky protocol error
hist_idx  in  log2(HIST_DEPTH)  history read index, 0 = newest
hist_pc  out  XLEN  history read data

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_VEC, pc_epoch=0, inflight=0, state=IDLE, pc_valid=0, flush=0, cmt_pulse=0, err=0, history cleared to 0.
- FSM: IDLE -> RUN on boot_en, sampled at clk. RUN is terminal until reset.
- pc_valid = (state==RUN) && inflight<MAX_INFLIGHT && !flush. Combinational from registers only; no input-to-pc_valid path.
- fire = pc_valid && pc_ready. On fire: pc <= pc+INST_BYTES, wrapping mod 2^XLEN, and inflight+1.
- While pc_valid && !pc_ready, pc and pc_epoch are held stable unless a redirect occurs.
- A commit is accepted when cmt_valid && cmt_epoch==pc_epoch. An accepted commit drives cmt_pulse=1 next cycle and decrements inflight.
- A commit with a stale epoch is dropped silently: no pulse, no count change.
- An accepted commit with inflight==0 sets err and is otherwise ignored.
- Redirect priority: trap_valid > accepted cmt_taken > sequential.
- On redirect: pc <= target with the low log2(INST_BYTES) bits forced to 0, epoch toggles, inflight <= 0, and flush=1 for the next cycle (pc_valid low during that cycle).
- A misaligned target sets err.
- Trap is taken regardless of commit epoch. On a trap, a same-cycle accepted commit still pulses cmt_pulse.
- Fire and accepted non-redirect commit in the same cycle: inflight unchanged.
- Fire and redirect in the same cycle: redirect wins. The fired PC leaves with the old epoch and is later dropped as stale.
- Latency: redirect target appears on pc with pc_valid 2 cycles after the redirect input (1 cycle flush bubble).

Optional Feature:
YSYX_PC_HIST_EN
- Defined: a HIST_DEPTH-entry ring buffer records cmt_pc of every accepted commit (write pointer wraps). hist_pc = entry hist_idx back from the newest, 1-cycle registered read. Entries never written read as 0.
- Undefined: no buffer is built; hist_pc is tied 0 and hist_idx is unused.

Decomposition:
- Package ysyx_24080014_pc_pkg holds: state enum {IDLE, RUN}, inflight width constant (3), INST_BYTES alignment-mask function.
- Sub-module ysyx_24080014_pc_hist holds the ring buffer, instantiated only under YSYX_PC_HIST_EN.

Test Plan:
- Reset, boot_en=1, pc_ready=1, no commits -> pc 0x80000000, 0x80000004, then pc_valid=0 with inflight=2 (MAX_INFLIGHT=2).
- Two current-epoch commits, cmt_taken=0 -> two cmt_pulse; inflight 2->0; fetch resumes at 0x80000008.
- Commit with cmt_taken=1, cmt_next_pc=0x80001000, in the same cycle as fire -> flush pulse, epoch 0->1, inflight 0, pc=0x80001000 valid two cycles later. A later commit with epoch 0 is dropped.
- trap_valid with trap_pc=0x80000100 and cmt_taken to 0x80002000 simultaneously -> pc=0x80000100.
- cmt_next_pc=0x80000102 -> pc=0x80000100, err=1 and stays set. Async rst asserted mid-cycle -> all outputs at reset values immediately.
- pc=0xFFFFFFFC, fire -> pc=0x00000000. With YSYX_PC_HIST_EN, commit 9 PCs -> hist_idx=0 returns the 9th and hist_idx=7 the 2nd.
